// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: latches a retiring bundle, drives per-lane RF writes,
// and serialises register-writing lanes through a trace FIFO onto debug_wb_*.
module wb_commit_stage #(
   parameter int unsigned LANES       = 2,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_W       = 5,
   parameter int unsigned TRACE_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [LANES-1:0]                  in_valid,
   input  logic [LANES*NUM_W-1:0]            in_writeNum,
   input  logic [LANES*DATA_W-1:0]           in_pc,
   input  logic [LANES*DATA_W-1:0]           in_data,
   input  logic                              flush,
   output logic                              okToChange,
   output logic [LANES-1:0]                  wb_writeEnable,
   output logic [LANES*NUM_W-1:0]            wb_writeNum,
   output logic [LANES*DATA_W-1:0]           wb_data,
   output logic [$clog2(TRACE_DEPTH+1)-1:0]  trace_count,
   output logic [DATA_W-1:0]                 debug_wb_pc,
   output logic [3:0]                        debug_wb_rf_wen,
   output logic [NUM_W-1:0]                  debug_wb_rf_wnum,
   output logic [DATA_W-1:0]                 debug_wb_rf_wdata
);
   localparam int unsigned PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(TRACE_DEPTH + 1);
   localparam int unsigned ENT_W = DATA_W + NUM_W + DATA_W;

   logic [LANES-1:0]        valid_q, valid_d;
   logic [LANES*NUM_W-1:0]  wnum_q, wnum_d;
   logic [LANES*DATA_W-1:0] pc_q, pc_d, data_q, data_d;
   logic [ENT_W-1:0]        mem_q [TRACE_DEPTH];
   logic [ENT_W-1:0]        mem_d [TRACE_DEPTH];
   logic [PTR_W-1:0]        rptr_q, rptr_d, wptr_q, wptr_d, widx;
   logic [CNT_W-1:0]        count_q, count_d, push_cnt;
   logic [DATA_W-1:0]       dbg_pc_q, dbg_pc_d, dbg_wdata_q, dbg_wdata_d;
   logic [NUM_W-1:0]        dbg_wnum_q, dbg_wnum_d;
   logic [3:0]              dbg_wen_q, dbg_wen_d;
   logic [LANES-1:0]        wen;
   logic                    pop;

   always_comb begin
      wen      = '0;
      push_cnt = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         wen[i]   = valid_q[i] && (wnum_q[i*NUM_W +: NUM_W] != '0);
         push_cnt = push_cnt + CNT_W'(wen[i]);
      end
   end

   // Uses the unflushed push count so acceptance depends on registered state only.
   assign okToChange = ({1'b0, count_q} + {1'b0, push_cnt}) <= (CNT_W+1)'(TRACE_DEPTH - LANES);

   always_comb begin
      valid_d = '0;
      wnum_d  = '0;
      pc_d    = pc_q;
      data_d  = data_q;
      if (!flush && okToChange) begin
         valid_d = in_valid;
         wnum_d  = in_writeNum;
         pc_d    = in_pc;
         data_d  = in_data;
      end
   end

   // A flush discards the held bundle, so its lanes are kept out of the trace.
   always_comb begin
      mem_d = mem_q;
      widx  = wptr_q;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (wen[i] && !flush) begin
            mem_d[widx] = {pc_q[i*DATA_W +: DATA_W], wnum_q[i*NUM_W +: NUM_W],
                           data_q[i*DATA_W +: DATA_W]};
            widx        = widx + 1'b1;
         end
      end
      wptr_d = widx;
      pop    = (count_q != '0);
      rptr_d = rptr_q + PTR_W'(pop);
      count_d = count_q + (flush ? CNT_W'(0) : push_cnt) - CNT_W'(pop);
      dbg_wen_d   = pop ? 4'hF : 4'h0;
      dbg_pc_d    = dbg_pc_q;
      dbg_wnum_d  = dbg_wnum_q;
      dbg_wdata_d = dbg_wdata_q;
      if (pop) begin
         {dbg_pc_d, dbg_wnum_d, dbg_wdata_d} = mem_q[rptr_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q     <= '0;
         wnum_q      <= '0;
         pc_q        <= '0;
         data_q      <= '0;
         rptr_q      <= '0;
         wptr_q      <= '0;
         count_q     <= '0;
         dbg_pc_q    <= '0;
         dbg_wnum_q  <= '0;
         dbg_wdata_q <= '0;
         dbg_wen_q   <= '0;
      end else begin
         valid_q     <= valid_d;
         wnum_q      <= wnum_d;
         pc_q        <= pc_d;
         data_q      <= data_d;
         rptr_q      <= rptr_d;
         wptr_q      <= wptr_d;
         count_q     <= count_d;
         dbg_pc_q    <= dbg_pc_d;
         dbg_wnum_q  <= dbg_wnum_d;
         dbg_wdata_q <= dbg_wdata_d;
         dbg_wen_q   <= dbg_wen_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign wb_writeEnable    = wen;
   assign wb_writeNum       = wnum_q;
   assign wb_data           = data_q;
   assign trace_count       = count_q;
   assign debug_wb_pc       = dbg_pc_q;
   assign debug_wb_rf_wen   = dbg_wen_q;
   assign debug_wb_rf_wnum  = dbg_wnum_q;
   assign debug_wb_rf_wdata = dbg_wdata_q;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: queue-based trace model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_commit_stage;
   localparam int LANES = 2, DATA_W = 32, NUM_W = 5, DEPTH = 4;

   logic                     clk = 1'b0;
   logic                     rst = 1'b0;
   logic [LANES-1:0]         in_valid = '0;
   logic [LANES*NUM_W-1:0]   in_writeNum = '0;
   logic [LANES*DATA_W-1:0]  in_pc = '0;
   logic [LANES*DATA_W-1:0]  in_data = '0;
   logic                     flush = 1'b0;
   logic                     okToChange;
   logic [LANES-1:0]         wb_writeEnable;
   logic [LANES*NUM_W-1:0]   wb_writeNum;
   logic [LANES*DATA_W-1:0]  wb_data;
   logic [2:0]               trace_count;
   logic [DATA_W-1:0]        debug_wb_pc;
   logic [3:0]               debug_wb_rf_wen;
   logic [NUM_W-1:0]         debug_wb_rf_wnum;
   logic [DATA_W-1:0]        debug_wb_rf_wdata;

   always #5 clk = ~clk;

   wb_commit_stage #(.LANES(LANES), .DATA_W(DATA_W), .NUM_W(NUM_W), .TRACE_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_writeNum(in_writeNum),
      .in_pc(in_pc), .in_data(in_data), .flush(flush), .okToChange(okToChange),
      .wb_writeEnable(wb_writeEnable), .wb_writeNum(wb_writeNum), .wb_data(wb_data),
      .trace_count(trace_count), .debug_wb_pc(debug_wb_pc),
      .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
      .debug_wb_rf_wdata(debug_wb_rf_wdata));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Behavioural model: held bundle per lane plus a queue of trace entries.
   typedef struct { logic [31:0] pc; logic [4:0] wn; logic [31:0] d; } ent_t;
   ent_t        mq[$];
   logic        m_valid [LANES];
   logic [4:0]  m_wn    [LANES];
   logic [31:0] m_pc    [LANES];
   logic [31:0] m_d     [LANES];
   logic [31:0] e_pc = '0, e_wd = '0;
   logic [4:0]  e_wn = '0;
   logic [3:0]  e_wen = '0;
   logic [31:0] rf [32];
   bit          started = 0;

   always @(posedge clk) begin
      if (!rst) begin
         mq.delete();
         for (int i = 0; i < LANES; i++) begin
            m_valid[i] = 1'b0; m_wn[i] = '0; m_pc[i] = '0; m_d[i] = '0;
         end
         e_pc = '0; e_wn = '0; e_wd = '0; e_wen = '0;
      end else begin
         int  pcnt;
         bit  ok;
         for (int i = 0; i < LANES; i++)
            if (wb_writeEnable[i]) rf[wb_writeNum[i*NUM_W +: NUM_W]] = wb_data[i*DATA_W +: DATA_W];
         pcnt = 0;
         for (int i = 0; i < LANES; i++) if (m_valid[i] && m_wn[i] != 0) pcnt++;
         ok = (mq.size() + pcnt) <= (DEPTH - LANES);
         if (mq.size() > 0) begin
            ent_t e;
            e = mq.pop_front();
            e_pc = e.pc; e_wn = e.wn; e_wd = e.d; e_wen = 4'hF;
         end else begin
            e_wen = 4'h0;
         end
         if (!flush)
            for (int i = 0; i < LANES; i++)
               if (m_valid[i] && m_wn[i] != 0) mq.push_back('{pc: m_pc[i], wn: m_wn[i], d: m_d[i]});
         for (int i = 0; i < LANES; i++) begin
            if (!flush && ok) begin
               m_valid[i] = in_valid[i];
               m_wn[i]    = in_writeNum[i*NUM_W +: NUM_W];
               m_pc[i]    = in_pc[i*DATA_W +: DATA_W];
               m_d[i]     = in_data[i*DATA_W +: DATA_W];
            end else begin
               m_valid[i] = 1'b0;
               m_wn[i]    = '0;
            end
         end
      end
   end

   int          peak = 0;
   int          stalls = 0;
   logic [31:0] seen_pc[$];
   logic [31:0] seen_d[$];

   always @(negedge clk) begin
      if (started) begin
         logic [LANES-1:0] en;
         int pcnt;
         en = '0;
         pcnt = 0;
         for (int i = 0; i < LANES; i++) begin
            en[i] = m_valid[i] && (m_wn[i] != 0);
            if (en[i]) pcnt++;
         end
         chk("okToChange", 64'(okToChange), 64'((mq.size() + pcnt) <= (DEPTH - LANES)));
         chk("wb_writeEnable", 64'(wb_writeEnable), 64'(en));
         for (int i = 0; i < LANES; i++) begin
            if (en[i]) begin
               chk("wb_writeNum", 64'(wb_writeNum[i*NUM_W +: NUM_W]), 64'(m_wn[i]));
               chk("wb_data", 64'(wb_data[i*DATA_W +: DATA_W]), 64'(m_d[i]));
            end
         end
         chk("trace_count", 64'(trace_count), 64'(mq.size()));
         chk("debug_wen", 64'(debug_wb_rf_wen), 64'(e_wen));
         chk("debug_pc", 64'(debug_wb_pc), 64'(e_pc));
         chk("debug_wnum", 64'(debug_wb_rf_wnum), 64'(e_wn));
         chk("debug_wdata", 64'(debug_wb_rf_wdata), 64'(e_wd));
         if (int'(trace_count) > peak) peak = int'(trace_count);
         if (!okToChange) stalls++;
         if (debug_wb_rf_wen == 4'hF) begin
            seen_pc.push_back(debug_wb_pc);
            seen_d.push_back(debug_wb_rf_wdata);
         end
      end
   end

   task automatic offer(input logic [1:0] v, input logic [4:0] n0, input logic [4:0] n1,
                        input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] d0, input logic [31:0] d1);
      bit acc;
      int tries;
      tries = 0;
      in_valid = v; in_writeNum = {n1, n0}; in_pc = {p1, p0}; in_data = {d1, d0};
      do begin
         acc = okToChange;
         @(negedge clk);
         tries++;
      end while (!acc && tries < 20);
      if (!acc) begin
         total++; bad++;
         $display("FAIL offer_timeout: accepted=0 expected=1");
      end
   endtask

   task automatic idle(input int n);
      in_valid = '0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit asc;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      started = 1;
      chk("rst_ok", 64'(okToChange), 64'd1);
      chk("rst_count", 64'(trace_count), 64'd0);
      chk("rst_wen", 64'(debug_wb_rf_wen), 64'd0);
      chk("rst_pc", 64'(debug_wb_pc), 64'd0);
      chk("rst_wnum", 64'(debug_wb_rf_wnum), 64'd0);
      chk("rst_wdata", 64'(debug_wb_rf_wdata), 64'd0);
      chk("rst_rfwe", 64'(wb_writeEnable), 64'd0);

      offer(2'b11, 5'd3, 5'd7, 32'h100, 32'h104, 32'hA, 32'hB);
      in_valid = '0;
      chk("single_we", 64'(wb_writeEnable), 64'h3);
      chk("single_wnum", 64'(wb_writeNum), 64'({5'd7, 5'd3}));
      chk("single_data", 64'(wb_data), {32'hB, 32'hA});
      @(negedge clk);
      chk("single_e1_count", 64'(trace_count), 64'd2);
      chk("single_e1_wen", 64'(debug_wb_rf_wen), 64'd0);
      @(negedge clk);
      chk("single_e2", {debug_wb_pc, 16'(debug_wb_rf_wnum), 12'(debug_wb_rf_wdata), debug_wb_rf_wen},
          {32'h100, 16'd3, 12'hA, 4'hF});
      @(negedge clk);
      chk("single_e3", {debug_wb_pc, 16'(debug_wb_rf_wnum), 12'(debug_wb_rf_wdata), debug_wb_rf_wen},
          {32'h104, 16'd7, 12'hB, 4'hF});
      @(negedge clk);
      chk("single_e4_wen", 64'(debug_wb_rf_wen), 64'd0);
      chk("single_e4_hold", 64'(debug_wb_pc), 64'h104);

      peak = 0; seen_pc.delete(); seen_d.delete();
      offer(2'b11, 5'd0, 5'd5, 32'h120, 32'h124, 32'h1, 32'h2);
      in_valid = '0;
      chk("zero_we", 64'(wb_writeEnable), 64'h2);
      idle(4);
      chk("zero_peak", 64'(peak), 64'd1);
      chk("zero_entries", 64'(seen_pc.size()), 64'd1);
      if (seen_pc.size() > 0) chk("zero_pc", 64'(seen_pc[0]), 64'h124);

      peak = 0; stalls = 0; seen_pc.delete(); seen_d.delete();
      for (int k = 0; k < 8; k++)
         offer(2'b11, 5'(k + 1), 5'(k + 9), 32'h200 + 32'(8 * k), 32'h204 + 32'(8 * k),
               32'(k), 32'(k + 100));
      idle(12);
      chk("bp_peak_le4", 64'(peak <= 4), 64'd1);
      chk("bp_entries", 64'(seen_pc.size()), 64'd16);
      asc = 1;
      for (int j = 1; j < seen_pc.size(); j++) if (seen_pc[j] <= seen_pc[j-1]) asc = 0;
      chk("bp_order", 64'(asc), 64'd1);
      chk("bp_throttled", 64'(stalls > 0), 64'd1);

      seen_pc.delete(); seen_d.delete();
      offer(2'b11, 5'd1, 5'd2, 32'h300, 32'h304, 32'h30, 32'h31);
      idle(1);
      offer(2'b11, 5'd3, 5'd4, 32'h400, 32'h404, 32'h40, 32'h41);
      in_valid = '0;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_we", 64'(wb_writeEnable), 64'd0);
      chk("flush_count", 64'(trace_count), 64'd0);
      idle(4);
      chk("flush_entries", 64'(seen_pc.size()), 64'd2);
      if (seen_pc.size() == 2) begin
         chk("flush_pc0", 64'(seen_pc[0]), 64'h300);
         chk("flush_pc1", 64'(seen_pc[1]), 64'h304);
      end

      seen_pc.delete(); seen_d.delete();
      for (int k = 0; k < 6; k++)
         offer(2'b11, 5'd9, 5'd9, 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k),
               32'(2 * k), 32'(2 * k + 1));
      idle(16);
      chk("wrap_entries", 64'(seen_d.size()), 64'd12);
      if (seen_d.size() == 12)
         for (int j = 0; j < 12; j++) chk("wrap_data", 64'(seen_d[j]), 64'(j));
      chk("wrap_rf_r9", 64'(rf[9]), 64'd11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_commit_stage.md
# wb_commit_stage

Parametrised writeback/commit stage for the multi-issue core. It latches a bundle of up to LANES retiring results from the re-execute stage. For one cycle it drives per-lane register-file write enables and forwarding data. It serialises every register-writing retirement through a small trace FIFO onto the single-channel debug_wb_* trace port. Backpressure to the upstream stage comes from FIFO occupancy, because the golden-trace port retires at most one write per cycle.

## Interface
- LANES, default 2: issue lanes per bundle (≥1).
- DATA_W, default 32: data and PC width.
- NUM_W, default 5: GPR index width.
- TRACE_DEPTH, default 4: trace FIFO entries; power of two, ≥ LANES.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  LANES  per-lane valid of the incoming bundle; any mask is legal.
- in_writeNum  in  LANES*NUM_W  lane i at [i*NUM_W +: NUM_W]; 0 means no write.
- in_pc  in  LANES*DATA_W  per-lane PC.
- in_data  in  LANES*DATA_W  per-lane result.
- flush  in  1  discard the bundle held in the stage register.
- okToChange  out  1  stage accepts a bundle at this edge.
- wb_writeEnable  out  LANES  per-lane register-file write enable.
- wb_writeNum  out  LANES*NUM_W  registered writeNum, also used for bypass compare.
- wb_data  out  LANES*DATA_W  registered result, also the forwarding data.
- trace_count  out  $clog2(TRACE_DEPTH+1)  current FIFO occupancy.
- debug_wb_pc  out  DATA_W  trace PC.
- debug_wb_rf_wen  out  4  trace write enable.
- debug_wb_rf_wnum  out  NUM_W  trace register number.
- debug_wb_rf_wdata  out  DATA_W  trace data.

## Operation
- Stage register: per-lane valid, writeNum, pc, data.
- Capture: when okToChange=1 and flush=0, the stage register loads the in_* values. When okToChange=0, the stage register loads all-invalid (bubble); the upstream stage holds its bundle.
- Flush: clears all lane valids and writeNum at the edge. Flush overrides capture. The held bundle produces no RF write and no trace push. FIFO contents are already retired and are untouched by flush.
- Write enable: wb_writeEnable[i] = lane_valid[i] && (writeNum[i] != 0).
- Same-destination lanes: when two lanes target the same register, both enables assert. The register file gives the higher lane index priority.
- Push set: each lane with wb_writeEnable[i]=1. All members of the push set are written into the FIFO at the next edge, in ascending lane order. push_cnt is the popcount of wb_writeEnable, range 0..LANES.
- Pop: on every edge where the FIFO is non-empty, the head is popped. Push and pop in the same edge are legal. There is no bypass: a pushed entry pops at the earliest one edge later.
- okToChange = (trace_count + push_cnt) ≤ TRACE_DEPTH − LANES. This is conservative (ignores the concurrent pop) and guarantees the FIFO never overflows. With the defaults, it requires count + push_cnt ≤ 2.
- Debug registers on a pop edge: pc, wnum and wdata take the head entry; debug_wb_rf_wen = 4'hF.
- Debug registers on a non-pop edge: debug_wb_rf_wen = 4'h0; pc, wnum and wdata hold their last values.
- Pointers: read and write pointers are $clog2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH. Occupancy is a separate counter: count_next = count + push_cnt − pop.
- Reset values (rst=0 at an edge): stage valids 0; writeNum, pc and data 0; FIFO pointers and count 0; all debug outputs 0. Consequently okToChange=1, wb_writeEnable=0 and trace_count=0 after reset.
- Reset mid-operation: in-flight bundle and FIFO entries are discarded with no trace output.

## Timing
- Edge E0: bundle captured.
- Cycle E0–E1: wb_writeEnable, wb_writeNum and wb_data valid, combinational from the stage register.
- Edge E1: push set written into the FIFO.
- Edge E2: lowest-lane entry appears on debug_wb_*. Each later entry appears one edge after the previous one.
- Trace throughput is 1 entry per cycle. Sustained bundles with push_cnt > 1 throttle okToChange.
- okToChange is purely combinational from registered state and has no path from in_*.

## Test plan
- Reset with rst=0 for 2 cycles, then release -> okToChange=1, trace_count=0, debug_wb_rf_wen=0, all debug fields 0.
- Single bundle: in_valid=2'b11, writeNums 3 and 7, pc 0x100 and 0x104, data 0xA and 0xB, captured at E0 -> wb_writeEnable=2'b11 during E0–E1; debug shows (0x100, 3, 0xA, wen F) after E2, then (0x104, 7, 0xB, wen F) after E3, then wen=0.
- Zero-destination lane: in_valid=2'b11, lane0 writeNum=0, lane1 writeNum=5 -> wb_writeEnable=2'b10; exactly one trace entry (lane1); trace_count peaks at 1.
- Backpressure: offer a full two-write bundle every cycle -> okToChange alternates so at most one entry is added per cycle on average. trace_count never exceeds 4, no entry is lost, and trace order is strictly ascending PC.
- Flush: capture a bundle with 2 writes and assert flush in the same cycle -> wb_writeEnable drops to 0 next cycle and no trace entries are added. Entries already queued still drain in order.
- Wrap and same destination: issue 6 bundles of 2 writes both to r9 (data 2k and 2k+1) -> read/write pointers wrap; all 12 trace entries appear in issue order; the RF final value of r9 is the last lane-1 data.
